exp_series_collector: RTL

//  Downstream stage of the e^-x Taylor-series engine. Captures the streamed partial sums
//  (dataout/output_valid) into a local buffer and detects convergence (first index i>=1 with
//  |s[i]-s[i-1]| <= TOL). On the engine's finish pulse it reports the final sum and the

---
 rtl/exp_coll_pkg.sv | 19 +
 rtl/exp_coll_buf.sv | 28 ++
 rtl/exp_series_collector.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/exp_coll_pkg.sv
// Shared definitions for the e^-x series collector: default sizes, FSM encoding
// and the "no convergence" marker.
package exp_coll_pkg;

   localparam int DW_DEF    = 10;
   localparam int DEPTH_DEF = 16;
   localparam int AW_DEF    = 4;
   localparam int TOL_DEF   = 1;

   localparam logic [AW_DEF-1:0] CONV_NONE = '1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      REPORT  = 2'd2,
      DRAIN   = 2'd3
   } state_t;

endpackage

// File: rtl/exp_coll_buf.sv
// Term buffer for the series collector: DEPTH x DW registers, one write port and
// one asynchronous read port. Contents are not reset.
module exp_coll_buf
   import exp_coll_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/exp_series_collector.sv
// Collects partial sums of the e^-x series, flags the first converged index and
// replays the stored terms. Optional min/max tracking under EXP_COLL_MINMAX_EN.
module exp_series_collector
   import exp_coll_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = AW_DEF,
   parameter int TOL   = TOL_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] sum_in,
   input  logic          sum_valid,
   input  logic          sum_finish,
   output logic          coll_ready,
   output logic [DW-1:0] result,
   output logic [AW-1:0] conv_idx,
   output logic [AW:0]   n_terms,
   output logic          overflow,
   output logic          result_valid,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic          rd_last
`ifdef EXP_COLL_MINMAX_EN
   ,
   output logic signed [DW-1:0] min_sum,
   output logic signed [DW-1:0] max_sum
`endif
);

   localparam logic [AW-1:0] NO_CONV = '1;

   state_t             state;
   logic [AW:0]        wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [DW-1:0]      last_sum;
   logic [AW-1:0]      conv_work;
   logic [DW-1:0]      buf_rdata;

   logic               collecting;
   logic               full;
   logic               store;
   logic               drop;
   logic signed [DW:0] diff;
   logic signed [DW:0] abs_diff;
   logic               hit;
   logic [AW:0]        n_next;
   logic [DW-1:0]      last_next;
   logic [AW-1:0]      conv_next;

   // The "next" values include a term arriving together with sum_finish, so the
   // report reflects it.
   always_comb begin
      collecting = (state == IDLE) || (state == COLLECT);
      full       = (wr_ptr == (AW+1)'(DEPTH));
      store      = sum_valid && collecting && !full;
      drop       = sum_valid && !store;
      diff       = $signed({sum_in[DW-1], sum_in}) - $signed({last_sum[DW-1], last_sum});
      abs_diff   = diff[DW] ? -diff : diff;
      hit        = store && (wr_ptr != '0) && (conv_work == NO_CONV) &&
                   (abs_diff <= (DW+1)'(TOL));
      n_next     = store ? wr_ptr + 1'b1 : wr_ptr;
      last_next  = store ? sum_in : last_sum;
      conv_next  = hit ? wr_ptr[AW-1:0] : conv_work;
   end

   exp_coll_buf #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_buf (
      .clk   (clk),
      .we    (store),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (sum_in),
      .raddr (rd_ptr),
      .rdata (buf_rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         last_sum     <= '0;
         conv_work    <= NO_CONV;
         coll_ready   <= 1'b1;
         result       <= '0;
         conv_idx     <= NO_CONV;
         n_terms      <= '0;
         overflow     <= 1'b0;
         result_valid <= 1'b0;
         rd_valid     <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         if (store) begin
            wr_ptr    <= n_next;
            last_sum  <= sum_in;
            conv_work <= conv_next;
         end
         if (state == IDLE && store) begin
            overflow <= 1'b0;
         end
         if (drop) begin
            overflow <= 1'b1;
         end
         case (state)
            IDLE, COLLECT: begin
               if (sum_finish) begin
                  state        <= REPORT;
                  coll_ready   <= 1'b0;
                  result_valid <= 1'b1;
                  result       <= (n_next == '0) ? '0 : last_next;
                  conv_idx     <= conv_next;
                  n_terms      <= n_next;
               end else if (store) begin
                  state <= COLLECT;
               end
            end
            REPORT: begin
               if (n_terms != '0) begin
                  state    <= DRAIN;
                  rd_valid <= 1'b1;
               end else begin
                  state      <= IDLE;
                  coll_ready <= 1'b1;
                  wr_ptr     <= '0;
                  rd_ptr     <= '0;
                  conv_work  <= NO_CONV;
               end
            end
            DRAIN: begin
               if (rd_ready) begin
                  if (rd_last) begin
                     state      <= IDLE;
                     rd_valid   <= 1'b0;
                     coll_ready <= 1'b1;
                     wr_ptr     <= '0;
                     rd_ptr     <= '0;
                     conv_work  <= NO_CONV;
                  end else begin
                     rd_ptr <= rd_ptr + 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign rd_last = rd_valid && ({1'b0, rd_ptr} == n_terms - 1'b1);
   assign rd_data = rd_valid ? buf_rdata : '0;

`ifdef EXP_COLL_MINMAX_EN
   // The first stored term of a series seeds both extremes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         min_sum <= '0;
         max_sum <= '0;
      end else if (store) begin
         if (wr_ptr == '0) begin
            min_sum <= $signed(sum_in);
            max_sum <= $signed(sum_in);
         end else begin
            if ($signed(sum_in) < min_sum) min_sum <= $signed(sum_in);
            if ($signed(sum_in) > max_sum) max_sum <= $signed(sum_in);
         end
      end
   end
`endif

endmodule
